// File: rtl/lenet_img_loader_pkg.sv
// Shared LeNet constants: image geometry, pixel width, write-index width and
// the encoding of the image-loader FSM.
package lenet_img_loader_pkg;

    localparam int LENET_DATA_W = 16;                             // half-float pixel
    localparam int LENET_IMG_W  = 32;                             // pixels per row
    localparam int LENET_IMG_H  = 32;                             // rows per frame
    localparam int LENET_IDX_W  = $clog2(LENET_IMG_W * LENET_IMG_H); // = 10

    // LOAD: accepting pixels into the buffer; FULL: frame held for the CNN.
    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } loader_state_t;

endpackage

// File: rtl/lenet_img_loader.sv
// Image loader: collects one raster-order frame of half-float pixels into a
// flat register buffer, then holds it stable for the LeNet core until the
// consumer acknowledges it. A SOF mid-frame restarts the frame and raises a
// sticky error flag.
module lenet_img_loader
    import lenet_img_loader_pkg::*;
#(
    parameter int DATA_WIDTH_1 = LENET_DATA_W,
    parameter int ImgInW       = LENET_IMG_W,
    parameter int ImgInH       = LENET_IMG_H
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [DATA_WIDTH_1-1:0]                pix_in,
    input  logic                                   pix_valid,
    input  logic                                   pix_sof,
    output logic                                   pix_ready,
    output logic [ImgInW*ImgInH*DATA_WIDTH_1-1:0]  CNNinput,
    output logic                                   img_valid,
    input  logic                                   img_ack,
    output logic [15:0]                            frame_cnt,
    output logic                                   sof_err
);

    localparam int NPix = ImgInW * ImgInH;
    localparam int IdxW = (NPix > 1) ? $clog2(NPix) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NPix - 1);

    loader_state_t   state_reg,     state_next;
    logic [IdxW-1:0] idx_reg,       idx_next;
    logic            sof_err_reg,   sof_err_next;
    logic [15:0]     frame_cnt_reg, frame_cnt_next;

    logic            transfer;
    logic [IdxW-1:0] wr_idx;
    logic [NPix-1:0] wr_en;

    // Handshake is decoded purely from state; a transfer needs LOAD and valid.
    assign pix_ready = (state_reg == LOAD);
    assign img_valid = (state_reg == FULL);
    assign transfer  = pix_valid && (state_reg == LOAD);
    // A SOF pixel always lands in word 0, whatever the current index is.
    assign wr_idx    = pix_sof ? '0 : idx_reg;

    assign frame_cnt = frame_cnt_reg;
    assign sof_err   = sof_err_reg;

    // State, index and status registers; reset wins over any transfer or ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= LOAD;
            idx_reg       <= '0;
            sof_err_reg   <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            sof_err_reg   <= sof_err_next;
            frame_cnt_reg <= frame_cnt_next;
        end
    end

    // Next-state logic: index advance, SOF restart, frame completion, release.
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        sof_err_next   = sof_err_reg;
        frame_cnt_next = frame_cnt_reg;
        case (state_reg)
            LOAD: begin
                if (transfer) begin
                    if (pix_sof) begin
                        // Restart: even a SOF on the last index is not completion.
                        idx_next = IdxW'(1);
                        if (idx_reg != '0) begin
                            sof_err_next = 1'b1;
                        end
                    end else if (idx_reg == LastIdx) begin
                        idx_next   = '0;
                        state_next = FULL;
                    end else begin
                        idx_next = idx_reg + IdxW'(1);
                    end
                end
            end
            FULL: begin
                if (img_ack) begin
                    state_next     = LOAD;
                    frame_cnt_next = frame_cnt_reg + 16'd1;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // Pixel buffer: one register per word with a decoded write enable, laid
    // out flat on CNNinput. Contents persist across frames until overwritten.
    genvar gi;
    generate
        for (gi = 0; gi < NPix; gi++) begin : g_pix
            logic [DATA_WIDTH_1-1:0] pix_word_reg;

            assign wr_en[gi] = transfer && (wr_idx == IdxW'(gi));

            // Word register: cleared by reset, loaded only on its own transfer.
            always_ff @(posedge clk) begin
                if (reset) begin
                    pix_word_reg <= '0;
                end else if (wr_en[gi]) begin
                    pix_word_reg <= pix_in;
                end
            end

            assign CNNinput[gi*DATA_WIDTH_1 +: DATA_WIDTH_1] = pix_word_reg;
        end
    endgenerate

endmodule
